// File: rtl/vm_pkg.sv
// Shared constants and helpers for the vending machine front end.
// Keeps the conditioner and controller in agreement on queue width.
package vm_pkg;

  localparam int VM_DEBOUNCE_CYCLES = 4;
  localparam int VM_MAX_PENDING     = 7;

  function automatic int vm_pend_w(
    input int max_pending
  );
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/vm_input_conditioner_if.sv
// Bundle between raw sensors, the conditioner and the controller.
// master: drives raw lines and ready; slave: the conditioner.
interface vm_input_conditioner_if
  import vm_pkg::*;
#(
  parameter int MAX_PENDING = VM_MAX_PENDING
);

  localparam int PW = vm_pend_w(MAX_PENDING);

  logic          coin_raw;
  logic          select_raw;
  logic          ready;
  logic          coin;
  logic          select;
  logic          overflow;
  logic [PW-1:0] coin_pending;

  modport master (
    output coin_raw,
    output select_raw,
    output ready,
    input  coin,
    input  select,
    input  coin_pending,
    input  overflow
  );

  modport slave (
    input  coin_raw,
    input  select_raw,
    input  ready,
    output coin,
    output select,
    output coin_pending,
    output overflow
  );

endinterface

// File: rtl/vm_debounce.sv
// 2-FF sync, counting debouncer and rising-edge press pulse.
// Ports: clk, reset_n, raw in; stable level and one-cycle press out.
module vm_debounce
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = VM_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic stable,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          stable_q;
  logic          stable_d;
  logic          press_q;
  logic          press_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      press_q  <= press_d;
      cnt_q    <= cnt_d;
    end
  end

  // Flip when the count would reach DEBOUNCE_CYCLES.
  always_comb begin
    stable_d = stable_q;
    press_d  = 1'b0;
    cnt_d    = '0;
    if (s2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = ~stable_q;
        press_d  = ~stable_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign stable = stable_q;
  assign press  = press_q;

endmodule

// File: rtl/vm_input_conditioner.sv
// Debounced coin/select front end with saturating coin credit queue.
// Ports: clk, reset_n, bus (slave): raw lines, ready, pulses, occupancy.
module vm_input_conditioner
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = VM_DEBOUNCE_CYCLES,
  parameter int MAX_PENDING     = VM_MAX_PENDING
) (
  input  logic                         clk,
  input  logic                         reset_n,
  vm_input_conditioner_if.slave        bus
);

  localparam int PW = vm_pend_w(MAX_PENDING);
  localparam logic [PW-1:0] FULL = PW'(MAX_PENDING);

  logic          coin_stable;
  logic          coin_press;
  logic          sel_stable;
  logic          sel_press;
  logic          coin_evt;
  logic          sel_evt;
  logic          issue;
  logic          sel_issue;

  logic [PW-1:0] pend_q;
  logic [PW-1:0] pend_d;
  logic          sel_pend_q;
  logic          sel_pend_d;
  logic          coin_q;
  logic          coin_d;
  logic          sel_q;
  logic          sel_d;
  logic          ovf_q;
  logic          ovf_d;

  vm_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_coin_db (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (bus.coin_raw),
    .stable (coin_stable),
    .press  (coin_press)
  );

  vm_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sel_db (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (bus.select_raw),
    .stable (sel_stable),
    .press  (sel_press)
  );

  assign coin_evt = coin_press & coin_stable;
  assign sel_evt  = sel_press & sel_stable;

  // Coins drain before select so credit lands first.
  assign issue     = bus.ready && (pend_q != '0);
  assign sel_issue = bus.ready && sel_pend_q &&
                     (pend_q == '0);

  always_comb begin
    pend_d     = pend_q;
    ovf_d      = 1'b0;
    coin_d     = issue;
    sel_d      = sel_issue;
    sel_pend_d = sel_pend_q;
    if (coin_evt && !issue && (pend_q == FULL)) begin
      ovf_d = 1'b1;
    end else begin
      pend_d = pend_q + PW'(coin_evt) - PW'(issue);
    end
    if (sel_issue) begin
      sel_pend_d = 1'b0;
    end else if (sel_evt) begin
      sel_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= '0;
      sel_pend_q <= 1'b0;
      coin_q     <= 1'b0;
      sel_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      sel_pend_q <= sel_pend_d;
      coin_q     <= coin_d;
      sel_q      <= sel_d;
      ovf_q      <= ovf_d;
    end
  end

  assign bus.coin         = coin_q;
  assign bus.select       = sel_q;
  assign bus.overflow     = ovf_q;
  assign bus.coin_pending = pend_q;

endmodule
